// File: rtl/tb_uart_rx_sniffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_sniffer                                           |
// | Description : Passive UART receiver that decodes 8N1 frames (or 8E1 when   |
// |               UART_SNIFF_PARITY_EN is defined) from a serial line, LSB     |
// |               first, idle high. Decoded bytes are buffered in a small      |
// |               FIFO. Framing errors, parity errors and FIFO overflow are    |
// |               flagged.                                                     |
// | Macro       : UART_SNIFF_PARITY_EN - adds an even-parity bit after DATA    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_sniffer #(
   parameter int ClkPerBit = 16,
   parameter int FifoDepth = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         rx_i,
   output logic [7:0]                   data_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [$clog2(FifoDepth):0]   level_o,
   output logic                         frame_err_o,
   output logic                         parity_err_o,
   output logic                         overflow_o,
   input  logic                         clear_i
);

   localparam int CW = $clog2(ClkPerBit);
   localparam int AW = $clog2(FifoDepth);
   localparam logic [CW-1:0] CNT_BIT  = CW'(ClkPerBit - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(ClkPerBit / 2 - 1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(FifoDepth);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_SNIFF_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif

   logic          sync1;
   logic          rx_q;
   logic          rx_prev;
   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          cnt_zero;
   logic          fall;

   logic          load_half;
   logic          load_bit;
   logic          shift_en;
   logic          push_req;
   logic          ferr_set;

   logic [7:0]    mem [FifoDepth];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          push_ok;

   assign cnt_zero = (cnt == '0);
   assign fall     = rx_prev & ~rx_q;

   // Two-flop synchronizer plus a delayed copy for start-edge detection; idle high
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1   <= 1'b1;
         rx_q    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx_i;
         rx_q    <= sync1;
         rx_prev <= rx_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // FSM next-state logic; mid-frame edges are ignored until back in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (fall) state_nxt = S_START;
         S_START:  if (cnt_zero) state_nxt = rx_q ? S_IDLE : S_DATA;
`ifdef UART_SNIFF_PARITY_EN
         S_DATA:   if (cnt_zero && bit_idx == 3'd7) state_nxt = S_PARITY;
         S_PARITY: if (cnt_zero) state_nxt = S_STOP;
`else
         S_DATA:   if (cnt_zero && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
         S_STOP:   if (cnt_zero) state_nxt = rx_q ? S_IDLE : S_BREAK;
         S_BREAK:  if (rx_q) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

`ifdef UART_SNIFF_PARITY_EN
   logic perr_set;
   logic par_bad;
`endif

   // FSM outputs: counter loads, shift strobe, push request and error strobes
   always_comb begin
      load_half = 1'b0;
      load_bit  = 1'b0;
      shift_en  = 1'b0;
      push_req  = 1'b0;
      ferr_set  = 1'b0;
`ifdef UART_SNIFF_PARITY_EN
      perr_set  = 1'b0;
`endif
      case (state)
         S_IDLE:  load_half = fall;
         S_START: load_bit  = cnt_zero & ~rx_q;
         S_DATA: begin
            shift_en = cnt_zero;
            load_bit = cnt_zero;
         end
`ifdef UART_SNIFF_PARITY_EN
         S_PARITY: begin
            load_bit = cnt_zero;
            perr_set = cnt_zero & (rx_q != ^shreg);
         end
         S_STOP: begin
            push_req = cnt_zero & rx_q & ~par_bad;
            ferr_set = cnt_zero & ~rx_q;
         end
`else
         S_STOP: begin
            push_req = cnt_zero & rx_q;
            ferr_set = cnt_zero & ~rx_q;
         end
`endif
         default: ;
      endcase
   end

   // Bit timing counter, bit index and LSB-first shift register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (load_half)     cnt <= CNT_HALF;
         else if (load_bit) cnt <= CNT_BIT;
         else if (!cnt_zero) cnt <= cnt - CW'(1);
         if (load_half)     bit_idx <= 3'd0;
         else if (shift_en) bit_idx <= bit_idx + 3'd1;
         if (shift_en)      shreg <= {rx_q, shreg[7:1]};
      end
   end

`ifdef UART_SNIFF_PARITY_EN
   // Parity verdict is held until the stop bit decides whether to push
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         par_bad      <= 1'b0;
         parity_err_o <= 1'b0;
      end else begin
         if (load_half)     par_bad <= 1'b0;
         else if (perr_set) par_bad <= 1'b1;
         parity_err_o <= perr_set;
      end
   end
`else
   assign parity_err_o = 1'b0;
`endif

   // Framing error pulse, one cycle after a low stop-bit sample
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) frame_err_o <= 1'b0;
      else         frame_err_o <= ferr_set;
   end

   // A push into a full FIFO is still accepted when the head is popped in the same cycle
   assign pop     = valid_o & ready_i;
   assign push_ok = push_req & ~clear_i & ((level_o != LVL_FULL) | pop);

   // FIFO storage; contents are only observable through the valid-gated head
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_o    <= '0;
         overflow_o <= 1'b0;
      end else if (clear_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_o    <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      level_o <= level_o + (AW+1)'(1);
         else if (!push_ok && pop) level_o <= level_o - (AW+1)'(1);
         if (push_req && !push_ok) overflow_o <= 1'b1;
      end
   end

   assign valid_o = (level_o != '0);
   assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_tb_uart_rx_sniffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tb_uart_rx_sniffer                                        |
// | Description : Directed self-checking bench for tb_uart_rx_sniffer          |
// |               (ClkPerBit=16, FifoDepth=8). Honours UART_SNIFF_PARITY_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tb_uart_rx_sniffer;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       ready;
   logic       clear;
   logic [7:0] data;
   logic       valid;
   logic [3:0] level;
   logic       frame_err;
   logic       parity_err;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;
   int fe_cnt   = 0;
   int pe_cnt   = 0;

   always #5 clk = ~clk;

   tb_uart_rx_sniffer #(.ClkPerBit(CPB), .FifoDepth(DEPTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rx_i         (rx),
      .data_o       (data),
      .valid_o      (valid),
      .ready_i      (ready),
      .level_o      (level),
      .frame_err_o  (frame_err),
      .parity_err_o (parity_err),
      .overflow_o   (overflow),
      .clear_i      (clear)
   );

   // Count error pulses away from the active edge
   always @(negedge clk) begin
      if (frame_err === 1'b1)  fe_cnt <= fe_cnt + 1;
      if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_bit(input logic b);
      rx = b;
      tick(CPB);
   endtask

   // Start bit, data bits LSB first, and a correct parity bit when enabled
   task automatic send_head(input logic [7:0] d);
      tx_bit(1'b0);
      for (int i = 0; i < 8; i++) tx_bit(d[i]);
`ifdef UART_SNIFF_PARITY_EN
      tx_bit(^d);
`endif
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_head(d);
      tx_bit(1'b1);
   endtask

   task automatic pop_n(input int n);
      ready = 1'b1;
      tick(n);
      ready = 1'b0;
   endtask

   initial begin
      rx    = 1'b1;
      ready = 1'b0;
      clear = 1'b0;
      rst_n = 1'b0;
      tick(3);
      check("rst_valid", valid, 0);
      check("rst_data", data, 8'h00);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      rst_n = 1'b1;
      tick(3);

      // Single frame 0x41 with exact stop-sample latency
      send_head(8'h41);
      rx = 1'b1;
      tick(10);
      check("lat_before", valid, 0);
      tick(1);
      check("lat_valid", valid, 1);
      check("lat_data", data, 8'h41);
      check("lat_level", level, 1);
      tick(5);
      check("f41_no_ferr", fe_cnt, 0);
      check("f41_no_perr", pe_cnt, 0);
      pop_n(1);
      check("pop_level", level, 0);
      check("pop_data_zero", data, 8'h00);

      // Pop while empty is ignored
      pop_n(2);
      check("empty_pop_level", level, 0);

      // Short low glitch is rejected at the start sample
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(40);
      check("glitch_level", level, 0);
      check("glitch_ferr", fe_cnt, 0);

      // Bad stop bit followed by a held-low line: exactly one framing error
      send_head(8'hA5);
      rx = 1'b0;
      tick(CPB + 40);
      rx = 1'b1;
      tick(20);
      check("break_ferr_once", fe_cnt, 1);
      check("break_level", level, 0);
      send_frame(8'h3C);
      tick(4);
      check("after_break_level", level, 1);
      check("after_break_data", data, 8'h3C);
      pop_n(1);

      // Nine frames with no pops: overflow, head is the first byte
      for (int i = 0; i < 9; i++) send_frame(8'h01 + 8'(i));
      check("ovf_level", level, DEPTH);
      check("ovf_flag", overflow, 1);
      check("ovf_head", data, 8'h01);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("clear_level", level, 0);
      check("clear_overflow", overflow, 0);
      check("clear_valid", valid, 0);

      // Full FIFO with a pop in the push cycle: level holds, no overflow
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
      check("full_level", level, DEPTH);
      check("full_no_ovf", overflow, 0);
      send_head(8'h5A);
      rx = 1'b1;
      tick(10);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("pushpop_level", level, DEPTH);
      check("pushpop_no_ovf", overflow, 0);
      check("pushpop_head", data, 8'h11);
      tick(5);
      pop_n(7);
      check("tail_data", data, 8'h5A);
      check("tail_level", level, 1);
      pop_n(1);
      check("drain_level", level, 0);

`ifdef UART_SNIFF_PARITY_EN
      // 0x07 has odd weight, so even parity bit is 1; send 0 first
      tx_bit(1'b0);
      for (int i = 0; i < 8; i++) tx_bit(((8'h07 >> i) & 8'h01) != 8'h00);
      tx_bit(1'b0);
      tx_bit(1'b1);
      tick(4);
      check("par_bad_perr", pe_cnt, 1);
      check("par_bad_level", level, 0);
      check("par_bad_no_ferr", fe_cnt, 1);
      send_frame(8'h07);
      tick(4);
      check("par_ok_level", level, 1);
      check("par_ok_data", data, 8'h07);
      check("par_ok_perr", pe_cnt, 1);
`else
      check("no_parity_pulses", pe_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
